// File: rtl/dm9000a_bus_engine.sv
// DM9000A host-bus engine: turns Iow / Ior / IOWR requests into timed
// CS#/CMD/IOW#/IOR# bus cycles and returns a one-cycle RunEnd per request.
module dm9000a_bus_engine #(
    parameter int T_SETUP   = 1,
    parameter int T_STROBE  = 3,
    parameter int T_HOLD    = 1,
    parameter int T_RECOVER = 2
) (
    input  logic        iDm9000aClk,
    input  logic        iReset,
    input  logic        iIow_RunStart,
    input  logic [15:0] iIow_Reg,
    input  logic [15:0] iIow_Data,
    output logic        oIow_RunEnd,
    input  logic        iIor_RunStart,
    input  logic [15:0] iIor_Reg,
    output logic        oIor_RunEnd,
    output logic [15:0] oIor_ReturnValue,
    input  logic        iIOWR_RunStart,
    input  logic        iIOWR_IndexOrData,
    input  logic [15:0] iIOWR_OutData,
    output logic        oIOWR_RunEnd,
    output logic        oDm9000aCS_n,
    output logic        oDm9000aCMD,
    output logic        oDm9000aIOW_n,
    output logic        oDm9000aIOR_n,
    output logic [15:0] oDm9000aDataOut,
    output logic        oDm9000aDataOE,
    input  logic [15:0] iDm9000aDataIn
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER, S_ACK, S_RELEASE
    } state_t;

    typedef enum logic [1:0] {OP_IOW, OP_IOR, OP_IOWR} op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        phase_q, phase_d;      // 0 = index phase, 1 = data phase
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] data_q, data_d;
    logic        cmd_q, cmd_d;
    logic        granted_start;

    logic        cs_n_nx, cmd_nx, iow_n_nx, ior_n_nx, oe_nx;
    logic [15:0] dout_nx;
    logic        iow_end_nx, ior_end_nx, iowr_end_nx;
    logic        active_nx, read_nx;

    // Dwell length of each timed state, minus one, loaded on state entry.
    function automatic logic [3:0] reload(state_t s);
        case (s)
            S_SETUP:   return 4'(T_SETUP - 1);
            S_STROBE:  return 4'(T_STROBE - 1);
            S_HOLD:    return 4'(T_HOLD - 1);
            S_RECOVER: return 4'(T_RECOVER - 1);
            default:   return 4'd0;
        endcase
    endfunction

    // State register plus the request fields latched at grant.
    always_ff @(posedge iDm9000aClk) begin
        // NOTE: synchronous reset -- iReset is only looked at on the clock edge.
        if (iReset) begin
            state_q <= S_IDLE;
            op_q    <= OP_IOW;
            phase_q <= 1'b0;
            cnt_q   <= 4'd0;
            idx_q   <= 16'd0;
            data_q  <= 16'd0;
            cmd_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            op_q    <= op_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
        end
    end

    // Next-state logic: grant, phase sequencing and dwell counting.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d = state_q;
        op_d    = op_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cmd_d   = cmd_q;

        case (op_q)
            OP_IOW:  granted_start = iIow_RunStart;
            OP_IOR:  granted_start = iIor_RunStart;
            default: granted_start = iIOWR_RunStart;
        endcase

        case (state_q)
            S_IDLE: begin
                if (iIow_RunStart) begin
                    op_d    = OP_IOW;
                    idx_d   = iIow_Reg;
                    data_d  = iIow_Data;
                    phase_d = 1'b0;
                    state_d = S_SETUP;
                end else if (iIor_RunStart) begin
                    op_d    = OP_IOR;
                    idx_d   = iIor_Reg;
                    phase_d = 1'b0;
                    state_d = S_SETUP;
                end else if (iIOWR_RunStart) begin
                    // Single-phase access: start directly in the last phase.
                    op_d    = OP_IOWR;
                    data_d  = iIOWR_OutData;
                    cmd_d   = iIOWR_IndexOrData;
                    phase_d = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP:   if (cnt_q == 4'd0) state_d = S_STROBE;
            S_STROBE:  if (cnt_q == 4'd0) state_d = S_HOLD;
            S_HOLD:    if (cnt_q == 4'd0) state_d = S_RECOVER;
            S_RECOVER: begin
                if (cnt_q == 4'd0) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK:     state_d = S_RELEASE;
            S_RELEASE: if (!granted_start) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            cnt_d = reload(state_d);
        else
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end

    // Output decode from the next state so the registered pins line up with it.
    always_comb begin
        active_nx   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        read_nx     = (op_d == OP_IOR) && phase_d;
        cs_n_nx     = !active_nx;
        cmd_nx      = oDm9000aCMD;
        dout_nx     = oDm9000aDataOut;
        if (active_nx) begin
            cmd_nx  = (op_d == OP_IOWR) ? cmd_d : phase_d;
            dout_nx = phase_d ? data_d : idx_d;
        end
        oe_nx       = active_nx && !read_nx;
        iow_n_nx    = !((state_d == S_STROBE) && !read_nx);
        ior_n_nx    = !((state_d == S_STROBE) && read_nx);
        iow_end_nx  = (state_d == S_ACK) && (op_d == OP_IOW);
        ior_end_nx  = (state_d == S_ACK) && (op_d == OP_IOR);
        iowr_end_nx = (state_d == S_ACK) && (op_d == OP_IOWR);
    end

    // Output registers, plus read-data capture on the last read-strobe cycle.
    always_ff @(posedge iDm9000aClk) begin
        if (iReset) begin
            oDm9000aCS_n     <= 1'b1;
            oDm9000aCMD      <= 1'b0;
            oDm9000aIOW_n    <= 1'b1;
            oDm9000aIOR_n    <= 1'b1;
            oDm9000aDataOut  <= 16'd0;
            oDm9000aDataOE   <= 1'b0;
            oIow_RunEnd      <= 1'b0;
            oIor_RunEnd      <= 1'b0;
            oIOWR_RunEnd     <= 1'b0;
            oIor_ReturnValue <= 16'd0;
        end else begin
            oDm9000aCS_n     <= cs_n_nx;
            oDm9000aCMD      <= cmd_nx;
            oDm9000aIOW_n    <= iow_n_nx;
            oDm9000aIOR_n    <= ior_n_nx;
            oDm9000aDataOut  <= dout_nx;
            oDm9000aDataOE   <= oe_nx;
            oIow_RunEnd      <= iow_end_nx;
            oIor_RunEnd      <= ior_end_nx;
            oIOWR_RunEnd     <= iowr_end_nx;
            if ((state_q == S_STROBE) && (cnt_q == 4'd0) && (op_q == OP_IOR) && phase_q)
                oIor_ReturnValue <= iDm9000aDataIn;
        end
    end

endmodule

// File: tb/tb_dm9000a_bus_engine.sv
// Directed bench for dm9000a_bus_engine: default timing instance plus a
// stretched-timing instance, expected values written out by hand.
module tb_dm9000a_bus_engine;

    logic        clk = 1'b0;
    logic        rst;
    int          n_cmp = 0;
    int          n_err = 0;

    // Default-timing instance signals.
    logic        iow_start, ior_start, iowr_start, iowr_cmd;
    logic [15:0] iow_reg, iow_data, ior_reg, iowr_data, din;
    logic        iow_end, ior_end, iowr_end;
    logic [15:0] ret_val, dout;
    logic        cs_n, cmd, iow_n, ior_n, oe;

    // Stretched-timing instance signals.
    logic        b_iowr_start, b_iowr_cmd;
    logic [15:0] b_iowr_data;
    logic        b_iow_end, b_ior_end, b_iowr_end;
    logic [15:0] b_ret_val, b_dout;
    logic        b_cs_n, b_cmd, b_iow_n, b_ior_n, b_oe;
    logic        b_zero = 1'b0;
    logic [15:0] b_zero16 = 16'd0;

    always #5 clk = ~clk;

    dm9000a_bus_engine dut (
        .iDm9000aClk(clk), .iReset(rst),
        .iIow_RunStart(iow_start), .iIow_Reg(iow_reg), .iIow_Data(iow_data), .oIow_RunEnd(iow_end),
        .iIor_RunStart(ior_start), .iIor_Reg(ior_reg), .oIor_RunEnd(ior_end), .oIor_ReturnValue(ret_val),
        .iIOWR_RunStart(iowr_start), .iIOWR_IndexOrData(iowr_cmd), .iIOWR_OutData(iowr_data),
        .oIOWR_RunEnd(iowr_end),
        .oDm9000aCS_n(cs_n), .oDm9000aCMD(cmd), .oDm9000aIOW_n(iow_n), .oDm9000aIOR_n(ior_n),
        .oDm9000aDataOut(dout), .oDm9000aDataOE(oe), .iDm9000aDataIn(din)
    );

    dm9000a_bus_engine #(.T_SETUP(2), .T_STROBE(5), .T_HOLD(2), .T_RECOVER(3)) dut_b (
        .iDm9000aClk(clk), .iReset(rst),
        .iIow_RunStart(b_zero), .iIow_Reg(b_zero16), .iIow_Data(b_zero16), .oIow_RunEnd(b_iow_end),
        .iIor_RunStart(b_zero), .iIor_Reg(b_zero16), .oIor_RunEnd(b_ior_end), .oIor_ReturnValue(b_ret_val),
        .iIOWR_RunStart(b_iowr_start), .iIOWR_IndexOrData(b_iowr_cmd), .iIOWR_OutData(b_iowr_data),
        .oIOWR_RunEnd(b_iowr_end),
        .oDm9000aCS_n(b_cs_n), .oDm9000aCMD(b_cmd), .oDm9000aIOW_n(b_iow_n), .oDm9000aIOR_n(b_ior_n),
        .oDm9000aDataOut(b_dout), .oDm9000aDataOE(b_oe), .iDm9000aDataIn(b_zero16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {15'd0, obs}, {15'd0, exp});
    endtask

    function automatic logic in_rng(input int k, input int a, input int b);
        return (k >= a) && (k <= b);
    endfunction

    // Single IOWR access on the default instance; request already raised in cycle 0.
    task automatic iowr_window(input string tag, input logic exp_cmd, input logic [15:0] exp_data);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_bit($sformatf("%s cs_n c%0d", tag, k), cs_n, !in_rng(k, 1, 5));
            check_bit($sformatf("%s iow_n c%0d", tag, k), iow_n, !in_rng(k, 2, 4));
            check_bit($sformatf("%s ior_n c%0d", tag, k), ior_n, 1'b1);
            check_bit($sformatf("%s oe c%0d", tag, k), oe, in_rng(k, 1, 5));
            check_bit($sformatf("%s runend c%0d", tag, k), iowr_end, k == 8);
            check_bit($sformatf("%s iow_end c%0d", tag, k), iow_end, 1'b0);
            if (in_rng(k, 1, 5)) begin
                check_bit($sformatf("%s cmd c%0d", tag, k), cmd, exp_cmd);
                check($sformatf("%s data c%0d", tag, k), dout, exp_data);
            end
            if (k == 8) iowr_start = 1'b0;
        end
        tick();
        tick();
    endtask

    initial begin
        int low_cnt;
        rst = 1'b1;
        iow_start = 0; ior_start = 0; iowr_start = 0; iowr_cmd = 0;
        iow_reg = 0; iow_data = 0; ior_reg = 0; iowr_data = 0; din = 16'hDEAD;
        b_iowr_start = 0; b_iowr_cmd = 0; b_iowr_data = 0;

        // Reset state.
        tick();
        tick();
        check_bit("rst cs_n", cs_n, 1'b1);
        check_bit("rst iow_n", iow_n, 1'b1);
        check_bit("rst ior_n", ior_n, 1'b1);
        check_bit("rst cmd", cmd, 1'b0);
        check("rst dout", dout, 16'h0000);
        check_bit("rst oe", oe, 1'b0);
        check_bit("rst iow_end", iow_end, 1'b0);
        check_bit("rst ior_end", ior_end, 1'b0);
        check_bit("rst iowr_end", iowr_end, 1'b0);
        check("rst retval", ret_val, 16'h0000);
        check_bit("rst b cs_n", b_cs_n, 1'b1);
        rst = 1'b0;

        // IOWR data write, default timing.
        iowr_start = 1'b1; iowr_cmd = 1'b1; iowr_data = 16'hA55A;
        iowr_window("iowr", 1'b1, 16'hA55A);

        // Iow: index then data phase.
        iow_start = 1'b1; iow_reg = 16'h00FC; iow_data = 16'h0005;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_bit($sformatf("iow cs_n c%0d", k), cs_n, !(in_rng(k, 1, 5) || in_rng(k, 8, 12)));
            check_bit($sformatf("iow iow_n c%0d", k), iow_n, !(in_rng(k, 2, 4) || in_rng(k, 9, 11)));
            check_bit($sformatf("iow oe c%0d", k), oe, in_rng(k, 1, 5) || in_rng(k, 8, 12));
            check_bit($sformatf("iow runend c%0d", k), iow_end, k == 15);
            if (in_rng(k, 1, 5)) begin
                check_bit($sformatf("iow cmd c%0d", k), cmd, 1'b0);
                check($sformatf("iow data c%0d", k), dout, 16'h00FC);
            end
            if (in_rng(k, 8, 12)) begin
                check_bit($sformatf("iow cmd c%0d", k), cmd, 1'b1);
                check($sformatf("iow data c%0d", k), dout, 16'h0005);
            end
        end
        iow_start = 1'b0;
        tick();
        tick();

        // Ior: index write then read strobe, data presented in cycles 9..11.
        ior_start = 1'b1; ior_reg = 16'h0001; din = 16'hDEAD;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 9) din = 16'h0040;
            if (k == 12) din = 16'hDEAD;
            check_bit($sformatf("ior cs_n c%0d", k), cs_n, !(in_rng(k, 1, 5) || in_rng(k, 8, 12)));
            check_bit($sformatf("ior iow_n c%0d", k), iow_n, !in_rng(k, 2, 4));
            check_bit($sformatf("ior ior_n c%0d", k), ior_n, !in_rng(k, 9, 11));
            check_bit($sformatf("ior oe c%0d", k), oe, in_rng(k, 1, 5));
            check_bit($sformatf("ior runend c%0d", k), ior_end, k == 15);
            check_bit($sformatf("ior iow_end c%0d", k), iow_end, 1'b0);
            if (in_rng(k, 1, 5)) check($sformatf("ior data c%0d", k), dout, 16'h0001);
            if (in_rng(k, 8, 12)) check_bit($sformatf("ior cmd c%0d", k), cmd, 1'b1);
            if (k == 11) check("ior retval early", ret_val, 16'h0000);
            if (k == 15) check("ior retval", ret_val, 16'h0040);
        end
        ior_start = 1'b0;
        tick();
        tick();

        // Iow and IOWR together, both held after Iow completes.
        iow_start = 1'b1; iow_reg = 16'h0002; iow_data = 16'h1234;
        iowr_start = 1'b1; iowr_cmd = 1'b0; iowr_data = 16'hBEEF;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_bit($sformatf("prio cs_n c%0d", k), cs_n, !(in_rng(k, 1, 5) || in_rng(k, 8, 12)));
            check_bit($sformatf("prio iow_end c%0d", k), iow_end, k == 15);
            check_bit($sformatf("prio iowr_end c%0d", k), iowr_end, 1'b0);
            if (in_rng(k, 8, 12)) check($sformatf("prio data c%0d", k), dout, 16'h1234);
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            check_bit($sformatf("held cs_n %0d", j), cs_n, 1'b1);
            check_bit($sformatf("held iow_end %0d", j), iow_end, 1'b0);
            check_bit($sformatf("held iowr_end %0d", j), iowr_end, 1'b0);
        end
        iow_start = 1'b0;
        tick();
        check_bit("gap cs_n", cs_n, 1'b1);
        iowr_window("iowr after iow", 1'b0, 16'hBEEF);
        check("retval held", ret_val, 16'h0040);

        // Reset during the Iow index strobe aborts the access.
        iow_start = 1'b1; iow_reg = 16'h0010; iow_data = 16'h0099;
        tick();
        tick();
        check_bit("abort iow_n strobe", iow_n, 1'b0);
        rst = 1'b1; iow_start = 1'b0;
        tick();
        rst = 1'b0;
        check_bit("abort cs_n", cs_n, 1'b1);
        check_bit("abort iow_n", iow_n, 1'b1);
        check_bit("abort oe", oe, 1'b0);
        check_bit("abort iow_end", iow_end, 1'b0);
        for (int j = 0; j < 16; j++) begin
            tick();
            check_bit($sformatf("abort quiet cs_n %0d", j), cs_n, 1'b1);
            check_bit($sformatf("abort quiet iow_end %0d", j), iow_end, 1'b0);
        end
        iowr_start = 1'b1; iowr_cmd = 1'b1; iowr_data = 16'h0F0F;
        iowr_window("iowr after rst", 1'b1, 16'h0F0F);

        // Stretched timing on the second instance.
        b_iowr_start = 1'b1; b_iowr_cmd = 1'b1; b_iowr_data = 16'h3C3C;
        low_cnt = 0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (!b_iow_n) low_cnt++;
            check_bit($sformatf("b cs_n c%0d", k), b_cs_n, !in_rng(k, 1, 9));
            check_bit($sformatf("b iow_n c%0d", k), b_iow_n, !in_rng(k, 3, 7));
            check_bit($sformatf("b runend c%0d", k), b_iowr_end, k == 13);
            if (in_rng(k, 1, 9)) check($sformatf("b data c%0d", k), b_dout, 16'h3C3C);
        end
        check("b strobe width", 16'(low_cnt), 16'd5);
        b_iowr_start = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
